// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the boot-image loader.
// Holds the two-state controller enum and the memory depth derived from WIDTH.
// Optional feature macro used by mem_loader: MEM_LOADER_RELOAD_EN.

package mem_loader_pkg;

    // Default data/address width; memory holds one byte per address.
    localparam int DEFAULT_WIDTH = 8;

    // Memory depth for the default width.
    localparam int DEPTH = 2 ** DEFAULT_WIDTH;

    // Controller states: LOAD fills memory from the loader stream with the
    // core held in reset, RUN hands the memory to the processor.
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Depth for an arbitrary width, used by parameterised instances.
    function automatic int depth_of(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: groups the processor bus, loader stream and core-control
// signals of mem_loader. The master side drives processor and loader inputs;
// the slave side is the mem_loader block itself.

interface mem_loader_if #(
    parameter int WIDTH = 8
);

    // Processor side
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;

    // Loader stream side
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic             ld_restart;

    // Core control
    logic             cpu_rst;
    logic             load_done;

    modport master (
        output memread, memwrite, adr, writedata,
        output ld_valid, ld_data, ld_last, ld_restart,
        input  memdata, ld_ready, cpu_rst, load_done
    );

    modport slave (
        input  memread, memwrite, adr, writedata,
        input  ld_valid, ld_data, ld_last, ld_restart,
        output memdata, ld_ready, cpu_rst, load_done
    );

endinterface

// File: rtl/mem_loader_ram_sp.sv
// ram_sp: single-port byte memory, one synchronous write port and an
// asynchronous read on the same address. Contents are never cleared, so an
// image survives a reset of the surrounding controller.

module ram_sp
    import mem_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int MEM_DEPTH = depth_of(WIDTH);

    logic [WIDTH-1:0] mem_q [MEM_DEPTH];

    // Write port: the only place memory contents change.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Asynchronous read: a write on the same address shows up next cycle,
    // so a read-during-write returns the old data.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_loader.sv
// mem_loader: streams a boot image into a byte memory while holding the
// processor core in reset, then releases the core and serves its bus.
// Optional feature: define MEM_LOADER_RELOAD_EN to let ld_restart return
// the block from RUN to LOAD; otherwise ld_restart is ignored.

module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    mem_loader_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    logic             ram_we;
    logic [WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    // Pointer sits on the last address: accepting this byte ends the load.
    logic             ptr_at_top;
    assign ptr_at_top = (ptr_q == {WIDTH{1'b1}});

    // memread carries no information for an asynchronous-read memory, and
    // ld_restart only matters when the reload feature is built in.
    logic unused_inputs;
    assign unused_inputs = bus.memread ^ bus.ld_restart;

    // State and load pointer registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state plus memory port steering: the loader owns the RAM in LOAD,
    // the processor owns it in RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ram_we    = 1'b0;
        ram_addr  = bus.adr;
        ram_wdata = bus.writedata;

        case (state_q)
            LOAD: begin
                ram_addr  = ptr_q;
                ram_wdata = bus.ld_data;
                if (bus.ld_valid) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (bus.ld_last || ptr_at_top) begin
                        state_d = RUN;
                        ptr_d   = '0;
                    end
                end
            end
            RUN: begin
                ram_we = bus.memwrite;
`ifdef MEM_LOADER_RELOAD_EN
                // The concurrent processor write still lands; only the
                // controller state is redirected.
                if (bus.ld_restart) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
`endif
            end
            default: begin
                state_d = LOAD;
                ptr_d   = '0;
            end
        endcase

        // A reset edge must not disturb memory contents.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    ram_sp #(
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Outputs decode directly from the registered state, so they change
    // exactly one cycle after the edge that moves the controller.
    always_comb begin
        bus.ld_ready  = (state_q == LOAD);
        bus.cpu_rst   = (state_q == LOAD);
        bus.load_done = (state_q == RUN);
        bus.memdata   = (state_q == RUN) ? ram_rdata : '0;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter WIDTH, default 8, data and address width; memory depth is 2**WIDTH bytes.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 memread  input  1  processor read strobe.
REQ-005 memwrite  input  1  processor write strobe.
REQ-006 adr  input  WIDTH  processor byte address.
REQ-007 writedata  input  WIDTH  processor write data.
REQ-008 memdata  output  WIDTH  read data to processor.
REQ-009 ld_valid  input  1  loader byte valid.
REQ-010 ld_data  input  WIDTH  loader byte.
REQ-011 ld_last  input  1  marks final loader byte; qualified by ld_valid.
REQ-012 ld_ready  output  1  loader may transfer this cycle.
REQ-013 ld_restart  input  1  request to re-enter load; active only with MEM_LOADER_RELOAD_EN.
REQ-014 cpu_rst  output  1  reset driven to processor core.
REQ-015 load_done  output  1  high while processor runs from loaded image.

Function
REQ-016 Two states: LOAD, RUN; state is registered.
REQ-017 LOAD: ld_ready=1, cpu_rst=1, load_done=0; memdata driven 0.
REQ-018 LOAD: byte transfers when ld_valid&ld_ready at clk edge; ld_data written at load pointer, pointer increments by 1.
REQ-019 LOAD->RUN on the edge accepting a byte with ld_last=1, or on the edge accepting the byte at address 2**WIDTH-1 (pointer wrap); no byte beyond address 2**WIDTH-1 is written.
REQ-020 First RUN cycle: cpu_rst=0, ld_ready=0, load_done=1 (all registered, one cycle after final transfer).
REQ-021 RUN: memdata = mem[adr] combinationally, same cycle, regardless of memread.
REQ-022 RUN: memwrite=1 writes writedata to mem[adr] at clk edge; read-during-write on same address returns old data that cycle.
REQ-023 LOAD: memwrite/memread ignored, no processor writes occur.
REQ-024 RUN: ld_valid/ld_data/ld_last ignored, no loader writes occur.
REQ-025 ld_valid with no ld_last and fewer than 2**WIDTH bytes: block stays in LOAD indefinitely.
REQ-026 ld_last sampled only on accepted transfers; ld_last with ld_valid=0 has no effect.

Reset
REQ-027 rst=1 at an edge: state=LOAD, pointer=0, cpu_rst=1, ld_ready=1, load_done=0 next cycle, in any state including mid-load.
REQ-028 rst has priority over transfer, write and ld_restart in the same cycle; no memory write occurs on that edge.
REQ-029 Memory contents are not cleared by rst.

Configuration
REQ-030 Macro MEM_LOADER_RELOAD_EN defined: ld_restart=1 in RUN at an edge returns to LOAD with pointer=0 and cpu_rst=1 next cycle; a concurrent memwrite on that edge still completes.
REQ-031 Macro undefined: ld_restart port exists but is ignored; only rst re-enters LOAD.

Structure
REQ-032 Shared package holds state enum (LOAD, RUN) and DEPTH constant derived from WIDTH.
REQ-033 One sub-module ram_sp: single write port, asynchronous read, parameterised by WIDTH; mem_loader muxes address/data/write-enable into it by state.

Verification
REQ-034 rst, stream 0x11,0x22,0x33 (last on 0x33) -> mem[0..2]=11,22,33; load_done=1 and cpu_rst=0 one cycle after 0x33.
REQ-035 RUN, adr=0x01 -> memdata=0x22 same cycle; memwrite adr=0x01 data=0xAB -> next cycle memdata=0xAB.
REQ-036 256 bytes, no ld_last -> RUN after byte at 0xFF; 257th ld_valid not accepted (ld_ready=0).
REQ-037 rst asserted after 2 of 4 bytes -> cpu_rst stays 1, pointer=0; reload of 0x55 lands at address 0.
REQ-038 LOAD with memwrite=1 adr=0x05 data=0xEE -> mem[5] unchanged; RUN with ld_valid=1 -> memory unchanged.
REQ-039 MEM_LOADER_RELOAD_EN: ld_restart pulse in RUN -> cpu_rst=1, ld_ready=1 next cycle; without macro, no change.
